// File: rtl/angle_range_reduce_pkg.sv
// cordic_pkg: state encoding, fixed-point angle constants and float field layout for the reducer
package cordic_pkg;
  localparam int FRAC = 24;
  localparam int OUT_W = FRAC + 8;
  localparam int W = 13 + FRAC;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_REDUCE = 3'd2;
  localparam logic [2:0] S_WRAP = 3'd3;
  localparam logic [2:0] S_FOLD = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [W-1:0] DEG90_Q = W'(90) << FRAC;
  localparam logic [W-1:0] DEG180_Q = W'(180) << FRAC;
  localparam logic [W-1:0] DEG270_Q = W'(270) << FRAC;
  localparam logic [W-1:0] DEG360_Q = W'(360) << FRAC;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;
  localparam int MAN_W = 23;
  localparam int EXP_BIAS = 127;
  localparam int MAX_EXP = 12;
endpackage

// File: rtl/angle_range_reduce_if.sv
// angle_range_reduce_if: float angle in, folded fixed-point angle out, valid/ready both ways
interface angle_range_reduce_if;
  logic [31:0] in_angle;
  logic in_valid;
  logic in_ready;
  logic [cordic_pkg::OUT_W-1:0] out_angle;
  logic [1:0] out_quad;
  logic out_cosneg;
  logic out_err;
  logic out_valid;
  logic out_ready;
  modport master (output in_angle, in_valid, out_ready,
                  input in_ready, out_angle, out_quad, out_cosneg, out_err, out_valid);
  modport slave (input in_angle, in_valid, out_ready,
                 output in_ready, out_angle, out_quad, out_cosneg, out_err, out_valid);
endinterface

// File: rtl/angle_range_reduce_fp_to_fixed.sv
// fp_to_fixed: single float to unsigned Q13.FRAC magnitude plus sign and range error
// Truncates toward zero unless ANGLE_REDUCE_ROUND_EN is defined (round half away from zero).
module fp_to_fixed
  import cordic_pkg::*;
(
  input  logic [31:0]  f,
  output logic [W-1:0] mag,
  output logic         sign,
  output logic         err
);
  localparam int PW = 64;
  localparam int PAD = PW - MAN_W - 1;
  // right-shift that turns the left-aligned mantissa into Q.FRAC units
  localparam logic [8:0] SH0 = 9'(EXP_BIAS + MAN_W + PAD - FRAC);
  logic [7:0] e;
  logic [8:0] s;
  logic [PW-1:0] p;
  logic [PW-1:0] q;
  always_comb begin
    e = f[EXP_MSB:EXP_LSB];
    s = SH0 - {1'b0, e};
    p = {1'b1, f[MAN_W-1:0], {PAD{1'b0}}};
`ifdef ANGLE_REDUCE_ROUND_EN
    q = ((p >> (s - 9'd1)) + PW'(1)) >> 1;
`else
    q = p >> s;
`endif
    sign = f[SIGN_BIT];
    err = e >= 8'(EXP_BIAS + MAX_EXP) || q[PW-1:FRAC+MAX_EXP] != '0;
    mag = (e == 8'd0 || err) ? '0 : q[W-1:0];
  end
endmodule

// File: rtl/angle_range_reduce.sv
// angle_range_reduce: float degrees -> modulo 360 -> folded [-90,+90] with quadrant for the CORDIC core
// Build option ANGLE_REDUCE_ROUND_EN selects rounding in the float decode.
module angle_range_reduce
  import cordic_pkg::*;
(
  input logic clk,
  input logic rst_n,
  angle_range_reduce_if.slave bus
);
  logic [2:0] state_q, state_d;
  logic [1:0] k_q, k_d;
  logic [31:0] fin_q, fin_d;
  logic [W-1:0] mag_q, mag_d;
  logic sign_q, sign_d, err_q, err_d;
  logic [OUT_W-1:0] oang_q, oang_d;
  logic [1:0] oquad_q, oquad_d;
  logic ocos_q, ocos_d, oerr_q, oerr_d, oval_q, oval_d;
  logic [W-1:0] dec_mag, sub;
  logic dec_sign, dec_err;
  logic [1:0] quad;
  logic [OUT_W-1:0] fold;
  fp_to_fixed u_dec (.f(fin_q), .mag(dec_mag), .sign(dec_sign), .err(dec_err));
  always_comb begin
    sub = DEG360_Q << k_q;
    quad = mag_q < DEG90_Q ? 2'd0 : mag_q < DEG180_Q ? 2'd1 : mag_q < DEG270_Q ? 2'd2 : 2'd3;
    fold = quad == 2'd0 ? OUT_W'(mag_q) :
           quad == 2'd3 ? OUT_W'(mag_q) - OUT_W'(DEG360_Q) : OUT_W'(DEG180_Q) - OUT_W'(mag_q);
  end
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    fin_d = fin_q;
    mag_d = mag_q;
    sign_d = sign_q;
    err_d = err_q;
    oang_d = oang_q;
    oquad_d = oquad_q;
    ocos_d = ocos_q;
    oerr_d = oerr_q;
    oval_d = oval_q;
    case (state_q)
      S_IDLE: begin
        fin_d = bus.in_valid ? bus.in_angle : fin_q;
        state_d = bus.in_valid ? S_DECODE : S_IDLE;
      end
      S_DECODE: begin
        mag_d = dec_mag;
        sign_d = dec_sign;
        err_d = dec_err;
        k_d = 2'd3;
        state_d = S_REDUCE;
      end
      S_REDUCE: begin
        mag_d = mag_q >= sub ? mag_q - sub : mag_q;
        k_d = k_q - 2'd1;
        state_d = k_q == 2'd0 ? S_WRAP : S_REDUCE;
      end
      S_WRAP: begin
        mag_d = (sign_q && mag_q != '0) ? DEG360_Q - mag_q : mag_q;
        state_d = S_FOLD;
      end
      S_FOLD: begin
        // an errored angle arrives here with mag 0, so it folds to quad 0, angle 0
        oang_d = fold;
        oquad_d = quad;
        ocos_d = quad == 2'd1 || quad == 2'd2;
        oerr_d = err_q;
        oval_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        oval_d = !bus.out_ready;
        state_d = bus.out_ready ? S_IDLE : S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q <= '0;
      fin_q <= '0;
      mag_q <= '0;
      sign_q <= 1'b0;
      err_q <= 1'b0;
      oang_q <= '0;
      oquad_q <= '0;
      ocos_q <= 1'b0;
      oerr_q <= 1'b0;
      oval_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      fin_q <= fin_d;
      mag_q <= mag_d;
      sign_q <= sign_d;
      err_q <= err_d;
      oang_q <= oang_d;
      oquad_q <= oquad_d;
      ocos_q <= ocos_d;
      oerr_q <= oerr_d;
      oval_q <= oval_d;
    end
  end
  assign bus.in_ready = state_q == S_IDLE;
  assign bus.out_angle = oang_q;
  assign bus.out_quad = oquad_q;
  assign bus.out_cosneg = ocos_q;
  assign bus.out_err = oerr_q;
  assign bus.out_valid = oval_q;
endmodule

// File: tb/tb_angle_range_reduce.sv
// tb_angle_range_reduce: directed and random angles checked against a real-arithmetic reference
module tb_angle_range_reduce;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  angle_range_reduce_if bus ();
  angle_range_reduce dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  localparam longint Q = 64'd1 << 24;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model(input logic [31:0] a, output logic [31:0] ang, output logic [1:0] qd,
                       output logic cn, output logic er);
    int ex;
    real v;
    longint m, r, qq;
    ex = int'(a[30:23]);
    er = 1'b0;
    m = 0;
    if (ex == 255) er = 1'b1;
    else if (ex != 0) begin
      v = real'({1'b1, a[22:0]}) * (2.0 ** (ex - 126));
`ifdef ANGLE_REDUCE_ROUND_EN
      v = v + 0.5;
`endif
      if (v >= 4096.0 * real'(Q)) er = 1'b1;
      else m = longint'($floor(v));
    end
    r = m % (360 * Q);
    if (a[31] && r != 0) r = 360 * Q - r;
    qq = r / (90 * Q);
    ang = er ? 32'd0 : 32'(qq == 0 ? r : qq == 3 ? r - 360 * Q : 180 * Q - r);
    qd = er ? 2'd0 : 2'(qq);
    cn = !er && (qq == 1 || qq == 2);
  endtask
  task automatic run(input logic [31:0] a, input int stall);
    logic [31:0] ea;
    logic [1:0] eq;
    logic ec, ee;
    int n;
    model(a, ea, eq, ec, ee);
    @(negedge clk);
    bus.out_ready = (stall == 0);
    bus.in_angle = a;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'd7);
    for (int i = 0; i <= stall; i++) begin
      chk("angle", 64'(bus.out_angle), 64'(ea));
      chk("quad", 64'(bus.out_quad), 64'(eq));
      chk("cosneg", 64'(bus.out_cosneg), 64'(ec));
      chk("err", 64'(bus.out_err), 64'(ee));
      chk("held", {62'd0, bus.out_valid, bus.in_ready}, 64'b10);
      if (i < stall) @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("drain", {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
  endtask
  initial begin
    bus.in_angle = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_state", {26'd0, bus.in_ready, bus.out_valid, bus.out_angle, bus.out_quad, bus.out_cosneg, bus.out_err},
        {26'd0, 1'b1, 1'b0, 32'd0, 2'd0, 1'b0, 1'b0});
    rst_n = 1'b1;
    run(32'h43340000, 0);
    run(32'hC1280000, 0);
    run(32'h44E10000, 0);
    run(32'h80000000, 0);
    run(32'h42B40000, 0);
    run(32'h3DCCCCCD, 0);
    run(32'h7F800000, 0);
    run(32'h45800000, 0);
    run(32'h43870000, 0);
    run(32'h457FFFFF, 0);
    run(32'hC3B40000, 5);
    @(negedge clk);
    bus.in_angle = 32'h44E10000;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst", {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
    chk("mid_rst_out", {28'd0, bus.out_angle, bus.out_quad, bus.out_cosneg, bus.out_err}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(32'hC1280000, 0);
    for (int i = 0; i < 40; i++) begin
      int sel;
      logic [7:0] ex;
      sel = int'($urandom_range(0, 9));
      ex = sel == 0 ? 8'hFF : sel == 1 ? 8'h00 : sel == 2 ? 8'(139 + $urandom_range(0, 2)) :
           8'($urandom_range(95, 138));
      run({1'($urandom_range(0, 1)), ex, 23'($urandom)}, (i % 7 == 3) ? 2 : 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
